pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 imem_req  output  1  instruction-fetch request; held high until acknowledged.
REQ-006 imem_addr  output  16  fetch address; equals pc.
REQ-007 imem_ack  input  1  fetch complete; imem_data is valid in the same cycle.
REQ-008 imem_data  input  16  fetched instruction word.
REQ-009 instr  output  16  latched current instruction.
REQ-010 instr_valid  output  1  one-cycle pulse; instr is ready for the datapath.
REQ-011 exec_done  input  1  datapath finished current instruction; flags and reg_target are valid.
REQ-012 flags  input  3  {Z,V,N} from the datapath flag register.
REQ-013 reg_target  input  16  rs value used by BR.
REQ-014 pc  output  16  address of current instruction.
REQ-015 pc_plus2  output  16  pc+2, modulo 2^16, combinational; used by PCS.
REQ-016 halted  output  1  high while in HALT.
REQ-017 redirect  output  1  one-cycle pulse when a taken branch updates pc.
REQ-018 retired  output  16  count of completed instructions; wraps modulo 2^16.

Function
REQ-019 The FSM SHALL have three states: FETCH, EXEC and HALT.
REQ-020 In FETCH, imem_req SHALL be 1; in EXEC and HALT it SHALL be 0.
REQ-021 FETCH with imem_ack=1 SHALL latch imem_data into instr on that edge.
REQ-022 That same FETCH-with-ack edge SHALL go to HALT if imem_data[15:12]=4'b1111, otherwise go to EXEC.
REQ-023 instr_valid SHALL be 1 during the first EXEC cycle only; minimum fetch-to-valid latency is 1 cycle after ack.
REQ-024 EXEC with exec_done=1 SHALL compute next pc, increment retired, and return to FETCH.
REQ-025 exec_done in the same cycle as instr_valid SHALL be accepted (1-cycle execute).
REQ-026 Opcodes 0xxx, 100x, 101x and 1110 (PCS) SHALL set next pc = pc+2.
REQ-027 Opcode 1100 (B) SHALL set next pc = pc+2 + (sext(instr[8:0]) << 1) when its condition is true, else pc+2.
REQ-028 Opcode 1101 (BR) SHALL set next pc = reg_target when its condition is true, else pc+2.
REQ-029 All next-pc arithmetic SHALL be 16-bit and wrap modulo 2^16; there is no overflow detection.
REQ-030 Branch conditions SHALL decode from instr[11:9], evaluated on flags sampled at exec_done: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-031 redirect SHALL pulse on the exec_done edge only when a B/BR is taken; it SHALL be 0 for not-taken branches and non-branches.
REQ-032 HALT SHALL be terminal until reset: pc holds the HLT address, halted=1, retired is unchanged, and all inputs are ignored.
REQ-033 imem_ack outside FETCH and exec_done outside EXEC SHALL be ignored.
REQ-034 imem_data SHALL be ignored while imem_ack=0; pc and imem_addr SHALL be stable while waiting for ack.

Reset
REQ-035 rst_n=0 at a clock edge SHALL force state=FETCH, pc=RESET_PC, instr=16'h0000, retired=0, instr_valid=0, redirect=0 and halted=0.
REQ-036 Reset SHALL take effect from any state, including mid-fetch, mid-execute and HALT; an in-flight ack or exec_done in the reset cycle SHALL be discarded.
REQ-037 imem_req SHALL be 1 in the first cycle after rst_n is released.

Verification
REQ-038 Reset release, ack after 3 cycles with 16'h1234 -> imem_addr=0000 throughout; instr_valid pulses the next cycle; after exec_done, pc=0002 and retired=1.
REQ-039 pc=0010, instr 16'hC1FE (B NE, offset -2), flags Z=0 -> next pc=000E, redirect pulse; same instruction with Z=1 -> pc=0012, no redirect.
REQ-040 pc=FFFE, ALU instruction -> pc wraps to 0000; B with cond 111 and offset +1 at pc=FFFC -> pc=0000.
REQ-041 BR cond 111 with reg_target=0x4A20 -> pc=4A20; BR cond 110 with V=0 -> pc+2.
REQ-042 Fetch 16'hF000 at pc=0006 -> HALT, halted=1, pc=0006, no instr_valid; later acks and exec_done have no effect; rst_n=0 -> pc=RESET_PC, FETCH.
REQ-043 Assert rst_n=0 in the same cycle as exec_done during EXEC -> retired=0, pc=RESET_PC, no redirect.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction word at a time, hands it to
// the datapath, then computes the next pc (sequential, relative branch or register branch).
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [2:0]  flags,
  input  logic [15:0] reg_target,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        halted,
  output logic        redirect,
  output logic [15:0] retired
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic [1:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_retired;
  logic        r_instr_valid;
  logic        r_redirect;

  logic [15:0] w_pc_plus2;
  logic [3:0]  w_opcode;
  logic [2:0]  w_cond;
  logic        w_z;
  logic        w_v;
  logic        w_n;
  logic        w_cond_true;
  logic        w_is_b;
  logic        w_is_br;
  logic        w_taken;
  logic [15:0] w_b_offset;
  logic [15:0] w_b_target;
  logic [15:0] w_next_pc;
  logic        w_fetch_is_hlt;

  assign w_pc_plus2 = r_pc + 16'd2;
  assign w_opcode   = r_instr[15:12];
  assign w_cond     = r_instr[11:9];
  // flags are packed {Z,V,N}
  assign w_z        = flags[2];
  assign w_v        = flags[1];
  assign w_n        = flags[0];

  always_comb begin
    w_cond_true = 1'b0;
    case (w_cond)
      3'b000:  w_cond_true = ~w_z;
      3'b001:  w_cond_true = w_z;
      3'b010:  w_cond_true = ~w_z & ~w_n;
      3'b011:  w_cond_true = w_n;
      3'b100:  w_cond_true = w_z | (~w_z & ~w_n);
      3'b101:  w_cond_true = w_n | w_z;
      3'b110:  w_cond_true = w_v;
      default: w_cond_true = 1'b1;
    endcase
  end

  assign w_is_b     = (w_opcode == OP_B);
  assign w_is_br    = (w_opcode == OP_BR);
  assign w_taken    = (w_is_b | w_is_br) & w_cond_true;
  // Word offset: sign-extend the 9-bit field and scale to bytes.
  assign w_b_offset = {{6{r_instr[8]}}, r_instr[8:0], 1'b0};
  assign w_b_target = w_pc_plus2 + w_b_offset;

  always_comb begin
    w_next_pc = w_pc_plus2;
    if (w_taken) begin
      w_next_pc = w_is_br ? reg_target : w_b_target;
    end
  end

  assign w_fetch_is_hlt = (imem_data[15:12] == OP_HLT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_instr       <= 16'h0000;
      r_retired     <= 16'h0000;
      r_instr_valid <= 1'b0;
      r_redirect    <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      r_redirect    <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_data;
            if (w_fetch_is_hlt) begin
              r_state <= S_HALT;
            end else begin
              r_state       <= S_EXEC;
              r_instr_valid <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            r_pc       <= w_next_pc;
            r_retired  <= r_retired + 16'd1;
            r_redirect <= w_taken;
            r_state    <= S_FETCH;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign pc_plus2    = w_pc_plus2;
  assign halted      = (r_state == S_HALT);
  assign redirect    = r_redirect;
  assign retired     = r_retired;

endmodule
